// File: rtl/gold_nic_if.sv
// gold_nic_if: processor register bus plus router link signals for gold_nic.
// master = PE/router environment, slave = the NIC itself.
interface gold_nic_if #(
    parameter int DATA_WIDTH = 64
);
    // processor register bus
    logic [1:0]            addr;
    logic [DATA_WIDTH-1:0] d_in;
    logic [DATA_WIDTH-1:0] d_out;
    logic                  nicEn;
    logic                  nicWrEn;
    // router link
    logic                  net_si;
    logic                  net_ri;
    logic [DATA_WIDTH-1:0] net_di;
    logic                  net_so;
    logic                  net_ro;
    logic [DATA_WIDTH-1:0] net_do;
    logic                  net_polarity;

    modport master (
        output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
        input  d_out, net_ri, net_so, net_do
    );

    modport slave (
        input  addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
        output d_out, net_ri, net_so, net_do
    );
endinterface

// File: rtl/gold_nic.sv
// gold_nic: network interface between a processing element and the router NIC port.
// One-entry output buffer (PE->router) gated by router polarity vs. the packet VC bit,
// one-entry input buffer (router->PE), registered processor read port.
// Optional feature macro: GOLD_NIC_DROP_CNT_EN adds a 16-bit saturating counter of
// dropped output-buffer writes, reported in the addr 11 status word and cleared by a
// write to addr 11.
module gold_nic #(
    parameter int DATA_WIDTH = 64,
    parameter int VC_BIT     = 63
) (
    input  logic        clk,
    input  logic        reset,
    gold_nic_if.slave   bus
);

    logic [DATA_WIDTH-1:0] obuf_r;
    logic                  obuf_full_r;
    logic [DATA_WIDTH-1:0] ibuf_r;
    logic                  ibuf_full_r;
    logic [DATA_WIDTH-1:0] d_out_r;
    logic [DATA_WIDTH-1:0] d_out_nxt_s;
    logic [DATA_WIDTH-1:0] obuf_stat_s;

    logic obuf_wr_req_s;
    logic obuf_wr_s;
    logic obuf_drop_s;
    logic xfer_s;
    logic capture_s;
    logic ibuf_rd_s;
    logic net_ri_s;

    // A packet only leaves on a cycle whose polarity matches its VC bit.
    assign xfer_s        = obuf_full_r & bus.net_ro & (bus.net_polarity == obuf_r[VC_BIT]);
    assign net_ri_s      = ~ibuf_full_r;
    assign capture_s     = bus.net_si & net_ri_s;
    assign obuf_wr_req_s = bus.nicEn & bus.nicWrEn & (bus.addr == 2'b10);
    // Writes are judged against the flag as sampled, so a write on a transfer edge is lost.
    assign obuf_wr_s     = obuf_wr_req_s & ~obuf_full_r;
    assign obuf_drop_s   = obuf_wr_req_s & obuf_full_r;
    assign ibuf_rd_s     = bus.nicEn & ~bus.nicWrEn & (bus.addr == 2'b00);

`ifdef GOLD_NIC_DROP_CNT_EN
    logic [15:0] drop_cnt_r;
    logic        drop_clr_s;

    assign drop_clr_s  = bus.nicEn & bus.nicWrEn & (bus.addr == 2'b11);
    assign obuf_stat_s = {{(DATA_WIDTH-17){1'b0}}, drop_cnt_r, obuf_full_r};

    // Saturating count of dropped output-buffer writes; software clears it via addr 11.
    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt_r <= 16'h0000;
        end else if (drop_clr_s) begin
            drop_cnt_r <= 16'h0000;
        end else if (obuf_drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end
`else
    assign obuf_stat_s = {{(DATA_WIDTH-1){1'b0}}, obuf_full_r};
`endif

    // Processor read mux; flags are sampled before any same-edge update.
    always_comb begin
        d_out_nxt_s = d_out_r;
        if (!bus.nicEn) begin
            d_out_nxt_s = {DATA_WIDTH{1'b0}};
        end else if (bus.nicWrEn) begin
            d_out_nxt_s = d_out_r;
        end else begin
            case (bus.addr)
                2'b00:   d_out_nxt_s = ibuf_r;
                2'b01:   d_out_nxt_s = {{(DATA_WIDTH-1){1'b0}}, ibuf_full_r};
                2'b10:   d_out_nxt_s = obuf_r;
                2'b11:   d_out_nxt_s = obuf_stat_s;
                default: d_out_nxt_s = {DATA_WIDTH{1'b0}};
            endcase
        end
    end

    // Output channel buffer: fill from the PE when empty, drain on a granted transfer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            obuf_r      <= {DATA_WIDTH{1'b0}};
            obuf_full_r <= 1'b0;
        end else if (obuf_wr_s) begin
            obuf_r      <= bus.d_in;
            obuf_full_r <= 1'b1;
        end else if (xfer_s) begin
            obuf_r      <= obuf_r;
            obuf_full_r <= 1'b0;
        end else begin
            obuf_r      <= obuf_r;
            obuf_full_r <= obuf_full_r;
        end
    end

    // Input channel buffer: capture from the router when empty, release on a PE read.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ibuf_r      <= {DATA_WIDTH{1'b0}};
            ibuf_full_r <= 1'b0;
        end else if (capture_s) begin
            ibuf_r      <= bus.net_di;
            ibuf_full_r <= 1'b1;
        end else if (ibuf_rd_s) begin
            ibuf_r      <= ibuf_r;
            ibuf_full_r <= 1'b0;
        end else begin
            ibuf_r      <= ibuf_r;
            ibuf_full_r <= ibuf_full_r;
        end
    end

    // Registered processor read data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            d_out_r <= {DATA_WIDTH{1'b0}};
        end else begin
            d_out_r <= d_out_nxt_s;
        end
    end

    assign bus.d_out  = d_out_r;
    assign bus.net_so = xfer_s;
    assign bus.net_ri = net_ri_s;
    assign bus.net_do = obuf_r;

endmodule

// File: tb/tb_gold_nic.sv
// tb_gold_nic: directed scenarios followed by randomized traffic, all checked against
// a behavioural model of the NIC's register and link rules.
// Build with GOLD_NIC_DROP_CNT_EN defined to also check the drop counter.
module tb_gold_nic;

    logic clk = 1'b0;
    logic reset;

    gold_nic_if #(.DATA_WIDTH(64)) bus ();

    gold_nic #(.DATA_WIDTH(64), .VC_BIT(63)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model state
    logic [63:0] m_obuf;
    logic [63:0] m_ibuf;
    logic [63:0] m_dout;
    bit          m_ob_full;
    bit          m_ib_full;
    int          m_drops;
    bit          m_valid = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ob_status();
`ifdef GOLD_NIC_DROP_CNT_EN
        return (64'(m_drops) << 1) | 64'(m_ob_full);
`else
        return 64'(m_ob_full);
`endif
    endfunction

    // One clock cycle: drive, check link outputs before the edge, advance model, check d_out.
    task automatic cyc(input bit en, input bit wr, input logic [1:0] a, input logic [63:0] din,
                       input bit si, input logic [63:0] di, input bit ro, input bit pol);
        bit pre_full;
        bit so_exp;
        bit ri_exp;
        bus.nicEn        = en;
        bus.nicWrEn      = wr;
        bus.addr         = a;
        bus.d_in         = din;
        bus.net_si       = si;
        bus.net_di       = di;
        bus.net_ro       = ro;
        bus.net_polarity = pol;
        #1;
        so_exp = m_ob_full && ro && (pol == m_obuf[63]);
        ri_exp = !m_ib_full;
        if (m_valid) begin
            chk("net_so", 64'(bus.net_so), 64'(so_exp));
            chk("net_ri", 64'(bus.net_ri), 64'(ri_exp));
            chk("net_do", bus.net_do, m_obuf);
        end
        @(posedge clk);
        if (!reset) begin
            m_obuf    = 64'h0;
            m_ibuf    = 64'h0;
            m_dout    = 64'h0;
            m_ob_full = 1'b0;
            m_ib_full = 1'b0;
            m_drops   = 0;
            m_valid   = 1'b1;
        end else if (m_valid) begin
            if (!en) m_dout = 64'h0;
            else if (!wr) begin
                case (a)
                    2'd0:    m_dout = m_ibuf;
                    2'd1:    m_dout = 64'(m_ib_full);
                    2'd2:    m_dout = m_obuf;
                    default: m_dout = ob_status();
                endcase
            end
            pre_full = m_ob_full;
            if (so_exp) m_ob_full = 1'b0;
            if (en && wr && a == 2'd2) begin
                if (!pre_full) begin
                    m_obuf    = din;
                    m_ob_full = 1'b1;
                end else if (m_drops < 65535) begin
                    m_drops++;
                end
            end
            if (en && wr && a == 2'd3) m_drops = 0;
            if (si && ri_exp) begin
                m_ibuf    = di;
                m_ib_full = 1'b1;
            end else if (en && !wr && a == 2'd0) begin
                m_ib_full = 1'b0;
            end
        end
        #1;
        if (m_valid) chk("d_out", bus.d_out, m_dout);
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] st;
        reset = 1'b0;
        bus.nicEn = 1'b0; bus.nicWrEn = 1'b0; bus.addr = 2'b00; bus.d_in = 64'h0;
        bus.net_si = 1'b0; bus.net_di = 64'h0; bus.net_ro = 1'b0; bus.net_polarity = 1'b0;
        @(negedge clk);

        // 1: reset with a flit offered
        cyc(1'b0, 1'b0, 2'b00, 64'h0, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 64'h0, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0);
        chk("t1_dout", bus.d_out, 64'h0);
        chk("t1_so", 64'(bus.net_so), 64'h0);
        chk("t1_ri", 64'(bus.net_ri), 64'h1);
        reset = 1'b1;
        cyc(1'b1, 1'b0, 2'b01, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        chk("t1_ibuf_stat", bus.d_out, 64'h0);

        // 2: inject, only on polarity 1
        cyc(1'b1, 1'b1, 2'b10, 64'h8033_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0);
        bus.net_polarity = 1'b1;
        #1;
        chk("t2_so", 64'(bus.net_so), 64'h1);
        chk("t2_do", bus.net_do, 64'h8033_0000_0000_0000);
        cyc(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 64'h0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 2'b11, 64'h0, 1'b0, 64'h0, 1'b1, 1'b1);
        chk("t2_ob_stat", bus.d_out, 64'h0);

        // 3: backpressure, then send on the first polarity 0 cycle
        cyc(1'b1, 1'b1, 2'b10, 64'h0022_0000_0000_0000, 1'b0, 64'h0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 2'b11, 64'h0, 1'b0, 64'h0, 1'b0, 1'($urandom_range(0, 1)));
            chk("t3_ob_stat", bus.d_out, 64'h1);
        end
        cyc(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 64'h0, 1'b1, 1'b1);
        bus.net_polarity = 1'b0;
        #1;
        chk("t3_so", 64'(bus.net_so), 64'h1);
        cyc(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0);

        // 4: back-to-back writes under backpressure, second one dropped
        cyc(1'b1, 1'b1, 2'b10, 64'h8022_0000_0000_0000, 1'b0, 64'h0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 2'b10, 64'h8033_0000_0000_0000, 1'b0, 64'h0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 2'b11, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1);
`ifdef GOLD_NIC_DROP_CNT_EN
        st = 64'h3;
`else
        st = 64'h1;
`endif
        chk("t4_ob_stat", bus.d_out, st);
        chk("t4_do", bus.net_do, 64'h8022_0000_0000_0000);
        cyc(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 64'h0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 2'b10, 64'h0, 1'b0, 64'h0, 1'b1, 1'b1);
        chk("t4_obuf", bus.d_out, 64'h8022_0000_0000_0000);
        cyc(1'b1, 1'b1, 2'b11, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);

        // 5: receive and read
        cyc(1'b0, 1'b0, 2'b00, 64'h0, 1'b1, 64'h800C_0000_0000_0000, 1'b0, 1'b0);
        chk("t5_ri", 64'(bus.net_ri), 64'h0);
        cyc(1'b1, 1'b0, 2'b01, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        chk("t5_ib_stat", bus.d_out, 64'h1);
        cyc(1'b1, 1'b0, 2'b00, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        chk("t5_ibuf", bus.d_out, 64'h800C_0000_0000_0000);
        chk("t5_ri_back", 64'(bus.net_ri), 64'h1);

        // 6: second flit held while the buffer is full
        cyc(1'b0, 1'b0, 2'b00, 64'h0, 1'b1, 64'h800C_0000_0000_0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 1'b0, 2'b00, 64'h0, 1'b1, 64'h000C_0000_0000_0000, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 2'b00, 64'h0, 1'b1, 64'h000C_0000_0000_0000, 1'b0, 1'b0);
        chk("t6_first", bus.d_out, 64'h800C_0000_0000_0000);
        cyc(1'b0, 1'b0, 2'b00, 64'h0, 1'b1, 64'h000C_0000_0000_0000, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 2'b00, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        chk("t6_second", bus.d_out, 64'h000C_0000_0000_0000);

        // randomized traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            reset = ($urandom_range(0, 39) != 0);
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                {$urandom, $urandom}, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
